req_arbiter: RTL and testbench
==============================

Name: req_arbiter

Overview:
- Four-requester arbiter that shares one downstream resource, for example a priority-encoded datapath port, between independent requesters.
- Selectable fixed-priority or round-robin policy.
- Registered one-hot grant plus encoded owner ID.
- Grant tenure is bounded by a hold counter so no requester can starve the others indefinitely.

Parameters:
- N_REQ, 4, number of requesters (block verified at 4 only).
- ID_W, 2, width of gnt_id; equals clog2(N_REQ).
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted; 0 means unlimited.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed priority (req[0] highest), 1 = round-robin.
- req  input  N_REQ  request vector, level-sensitive; requester holds high while it wants the resource.
- gnt  output  N_REQ  one-hot registered grant.
- gnt_id  output  ID_W  index of current owner; 0 when no grant.
- valid  output  1  high when any grant is asserted (equals OR of gnt).

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, gnt_id=0, valid=0, state=IDLE, hold_cnt=0.
  - rr_ptr=N_REQ-1, so the first round-robin search starts at requester 0.
  - Outputs clear immediately on rst falling, without waiting for clk.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select a winner, go to GRANT, set gnt[winner]=1, gnt_id=winner, valid=1, hold_cnt=1.
  - Latency: gnt is visible on the first clk edge after req is sampled high.
- Winner selection, combinational on req and mode:
  - mode=0: lowest-index set bit of req.
  - mode=1: first set bit searching upward from (rr_ptr+1) mod N_REQ, wrapping.
  - rr_ptr is loaded with the winner index on every grant, in both modes.
- GRANT:
  - If req[owner]=0, go to RELEASE.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD, go to RELEASE (timeout).
  - Else stay in GRANT and hold_cnt++.
  - gnt is therefore asserted for at most MAX_HOLD cycles per tenure.
  - Requests from other requesters have no effect during GRANT; there is no preemption.
- RELEASE:
  - Lasts exactly one cycle with gnt=0, gnt_id=0, valid=0; then go to IDLE.
  - Arbitration resumes from IDLE, so the minimum gap between tenures is 2 cycles of gnt low (RELEASE, then IDLE evaluation edge).
- Timeout with owner still requesting:
  - mode=0: the owner may win again if it remains highest priority.
  - mode=1: rr_ptr=owner, so other active requesters win first.
- mode is sampled only in IDLE. Changing mode during GRANT or RELEASE does not affect the current tenure.
- gnt is always one-hot or zero; gnt_id==index of set bit; valid==|gnt in every cycle.
- hold_cnt width is clog2(MAX_HOLD+1). There is no wrap in unlimited mode, since the counter does not increment when MAX_HOLD==0.
- Reset asserted mid-tenure: grant drops asynchronously. After rst rises, the block resumes from IDLE with rr_ptr=N_REQ-1.

Test Plan:
1. Reset and single requester:
   - Stimulus: rst=0, then rst=1, req=0100, mode=0.
   - Response: gnt=0 during reset. gnt=0100, gnt_id=2, valid=1 one edge after req is sampled. Drop req, then gnt=0 on the next edge (RELEASE).
2. Fixed priority:
   - Stimulus: mode=0, req=1110 held.
   - Response: gnt=0010 (id 1) for exactly 8 cycles, then 1 RELEASE cycle and 1 IDLE cycle, then gnt=0010 again. Requesters 2 and 3 are never granted.
3. Round-robin rotation:
   - Stimulus: mode=1, req=1111 held after reset.
   - Response: grant order is id 0,1,2,3,0. Each tenure is 8 cycles of gnt high, separated by 2 cycles of gnt low.
4. Round-robin wrap:
   - Stimulus: mode=1, rr_ptr=2 after a grant to id 2, then req=0101.
   - Response: next gnt=0001 (id 0), following that gnt=0100 (id 2).
5. Early release and no preemption:
   - Stimulus: owner id 3 granted. req[0] rises at cycle 2; req[3] drops at cycle 4.
   - Response: gnt stays 1000 until req[3] drops. RELEASE follows, then gnt=0001.
6. Mid-tenure reset and mode change:
   - Stimulus: during GRANT of id 1 (mode=0), toggle mode=1 and then pulse rst=0 between clk edges.
   - Response: the mode toggle does not alter the current grant. gnt=0, valid=0 immediately on rst low. After rst=1 with req=1111, mode=1, the first grant is id 0.

Source files
------------

// File: rtl/req_arbiter.sv
// req_arbiter: four-requester arbiter with fixed-priority or round-robin
// selection and a hold counter that bounds each grant tenure.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; arbitrate among active requests on each edge
//   GRANT   | owner holds the resource; gnt[owner] asserted
//   RELEASE | one-cycle gap with gnt low before arbitration resumes
module req_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             valid
);

    // A zero-width counter is not legal, so unlimited mode keeps one idle bit.
    localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic            win_found;
    logic [ID_W-1:0] win_id;

    // Winner selection; loops run from lowest to highest priority so the
    // last hit (highest priority) is the one that sticks.
    always_comb begin
        logic [ID_W-1:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        if (!mode) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req[ID_W'(i)]) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(i);
                end
            end
        end else begin
            // Index arithmetic wraps modulo N_REQ because N_REQ == 2**ID_W.
            for (int i = N_REQ; i >= 1; i--) begin
                idx = rr_ptr_q + ID_W'(i);
                if (req[idx]) begin
                    win_found = 1'b1;
                    win_id    = idx;
                end
            end
        end
    end

    // State, owner, round-robin pointer and hold counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= LAST_ID;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // Next-state logic: grant from IDLE, bounded tenure in GRANT, one-cycle RELEASE.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (win_found) begin
                    state_d  = GRANT;
                    owner_d  = win_id;
                    rr_ptr_d = win_id;
                    hold_d   = HC_W'(1);
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = RELEASE;
                    hold_d  = '0;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LIM)) begin
                    state_d = RELEASE;
                    hold_d  = '0;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
                owner_d = '0;
                hold_d  = '0;
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs decode straight from flops, so they clear as soon as rst falls.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        valid  = 1'b0;
        if (state_q == GRANT) begin
            gnt[owner_q] = 1'b1;
            gnt_id       = owner_q;
            valid        = 1'b1;
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: per-cycle vector table plus hand-written
// sequences for timeout, rotation and asynchronous reset.
module tb_req_arbiter;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       valid;

    int n_cmp  = 0;
    int n_fail = 0;

    req_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] eid);
        logic ev;
        ev = |eg;
        n_cmp++;
        if (gnt !== eg || gnt_id !== eid || valid !== ev) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
                     nm, gnt, gnt_id, valid, eg, eid, ev);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, check at next negedge.
    task automatic step(input string nm, input logic [3:0] r, input logic m,
                        input logic [3:0] eg, input logic [1:0] eid);
        req  = r;
        mode = m;
        @(posedge clk);
        @(negedge clk);
        check(nm, eg, eid);
    endtask

    task automatic do_reset();
        req  = 4'b0000;
        mode = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 4'b0000, 2'd0);
        rst = 1'b1;
    endtask

    initial begin
        rst  = 1'b0;
        req  = 4'b0000;
        mode = 1'b0;

        // single requester, round-robin wrap, no preemption, fixed priority
        vecs[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[4]  = '{4'b0101, 1'b1, 4'b0001, 2'd0};
        vecs[5]  = '{4'b0100, 1'b1, 4'b0000, 2'd0};
        vecs[6]  = '{4'b0100, 1'b1, 4'b0000, 2'd0};
        vecs[7]  = '{4'b0100, 1'b1, 4'b0100, 2'd2};
        vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd0};
        vecs[10] = '{4'b1000, 1'b0, 4'b1000, 2'd3};
        vecs[11] = '{4'b1000, 1'b0, 4'b1000, 2'd3};
        vecs[12] = '{4'b1001, 1'b0, 4'b1000, 2'd3};
        vecs[13] = '{4'b1001, 1'b0, 4'b1000, 2'd3};
        vecs[14] = '{4'b0001, 1'b0, 4'b0000, 2'd0};
        vecs[15] = '{4'b0001, 1'b0, 4'b0000, 2'd0};
        vecs[16] = '{4'b0001, 1'b0, 4'b0001, 2'd0};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[18] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[19] = '{4'b1010, 1'b0, 4'b0010, 2'd1};
        vecs[20] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
        vecs[21] = '{4'b0000, 1'b0, 4'b0000, 2'd0};

        @(negedge clk);
        do_reset();

        for (int v = 0; v < 22; v++) begin
            step($sformatf("vec%0d", v), vecs[v].req, vecs[v].mode, vecs[v].gnt, vecs[v].id);
        end

        // Fixed priority with req=1110 held: id 1 for 8 cycles, 2 low, repeat.
        for (int c = 1; c <= 20; c++) begin
            logic [3:0] eg;
            eg = (((c - 1) % 10) < 8) ? 4'b0010 : 4'b0000;
            step($sformatf("fixed_c%0d", c), 4'b1110, 1'b0, eg, (eg != 0) ? 2'd1 : 2'd0);
        end
        step("fixed_drop", 4'b0000, 1'b0, 4'b0000, 2'd0);

        // Round-robin rotation from reset: ids 0,1,2,3,0.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 10; c++) begin
                logic [1:0] eid;
                logic [3:0] eg;
                eid = 2'(t % 4);
                eg  = (c < 8) ? (4'b0001 << eid) : 4'b0000;
                step($sformatf("rr_t%0d_c%0d", t, c), 4'b1111, 1'b1, eg, (c < 8) ? eid : 2'd0);
            end
        end
        step("rr_drop", 4'b0000, 1'b1, 4'b0000, 2'd0);

        // Mode change mid-tenure, then asynchronous reset between edges.
        step("m6_grant", 4'b0010, 1'b0, 4'b0010, 2'd1);
        step("m6_modetog1", 4'b0011, 1'b1, 4'b0010, 2'd1);
        step("m6_modetog2", 4'b0011, 1'b1, 4'b0010, 2'd1);
        #2 rst = 1'b0;
        #1 check("m6_async_rst", 4'b0000, 2'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        step("m6_after_rst", 4'b1111, 1'b1, 4'b0001, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
